edge_pair_gen: RTL and testbench

Temporal edge generator that drives the comparator's edge-resolve stage. It accepts a pair of binary values over a valid/ready handshake and converts each value into a rising step edge at a cycle offset equal to that value, inside a fixed-length frame. Before each frame it pulses a dedicated active-low clear to the downstream resolver. It is the encoding end of the x/y edge interface that `comp_edge_resolve` decodes.

---
 rtl/lfsr_comp_pkg.sv | 6 +
 rtl/edge_thresh_reg.sv | 33 +++
 rtl/edge_pair_gen.sv | 95 +++++++++
 tb/tb_edge_pair_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/lfsr_comp_pkg.sv
// lfsr_comp_pkg: shared types and defaults for the x/y edge generator and its resolver benches
package lfsr_comp_pkg;
    localparam int VAL_W_DEF   = 4;
    localparam int GAP_CYC_DEF = 2;
    typedef enum logic [1:0] {IDLE, CLEAR, RUN} edge_gen_state_t;
endpackage

// File: rtl/edge_thresh_reg.sv
// edge_thresh_reg: one edge channel; latches a value and drives a registered step edge once k >= value
//   load_i : latch val_i (handshake cycle)
//   k_i    : next-cycle run count
//   run_i  : next cycle is a RUN cycle (edge forced low otherwise)
//   edge_o : registered step edge
module edge_thresh_reg #(
    parameter int VAL_W = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load_i,
    input  logic [VAL_W-1:0] val_i,
    input  logic [VAL_W-1:0] k_i,
    input  logic             run_i,
    output logic             edge_o
);
    logic [VAL_W-1:0] val_q, val_d;
    logic             edge_q, edge_d;
    always_comb begin
        val_d  = load_i ? val_i : val_q;
        edge_d = run_i && (k_i >= val_q);
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            val_q  <= '0;
            edge_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            edge_q <= edge_d;
        end
    end
    assign edge_o = edge_q;
endmodule

// File: rtl/edge_pair_gen.sv
// edge_pair_gen: converts an accepted x/y value pair into two step edges inside a CLEAR+RUN frame
//   in_valid/in_ready : pair handshake, accepted only in IDLE
//   x_val/y_val       : edge offsets within RUN
//   x_edge/y_edge     : registered step edges
//   edge_rst_b        : registered active-low clear to the resolver, low during CLEAR
//   frame_done        : one-cycle pulse in the first IDLE cycle after RUN
module edge_pair_gen
    import lfsr_comp_pkg::*;
#(
    parameter int VAL_W   = VAL_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] x_val,
    input  logic [VAL_W-1:0] y_val,
    output logic             x_edge,
    output logic             y_edge,
    output logic             edge_rst_b,
    output logic             frame_done
);
    localparam int            GW       = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    edge_gen_state_t  state_q, state_d;
    logic [VAL_W-1:0] k_q, k_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             in_ready_q, edge_rst_b_q, frame_done_q;
    logic             accept, run_d;

    // in_ready_q is only high in IDLE, so it doubles as the accept qualifier
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CLEAR;
                    gap_d   = '0;
                end
            end
            CLEAR: begin
                if (gap_q == GAP_LAST) begin
                    state_d = RUN;
                    k_d     = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            RUN: begin
                if (&k_q) state_d = IDLE;
                else      k_d     = k_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        run_d = (state_d == RUN);
    end

    // Outputs are computed from next-state values so every output is a flop
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            k_q          <= '0;
            gap_q        <= '0;
            in_ready_q   <= 1'b0;
            edge_rst_b_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            gap_q        <= gap_d;
            in_ready_q   <= (state_d == IDLE);
            edge_rst_b_q <= (state_d != CLEAR);
            frame_done_q <= (state_q == RUN) && (state_d == IDLE);
        end
    end

    edge_thresh_reg #(.VAL_W(VAL_W)) u_x (
        .clk(clk), .rst_b(rst_b), .load_i(accept), .val_i(x_val),
        .k_i(k_d), .run_i(run_d), .edge_o(x_edge)
    );
    edge_thresh_reg #(.VAL_W(VAL_W)) u_y (
        .clk(clk), .rst_b(rst_b), .load_i(accept), .val_i(y_val),
        .k_i(k_d), .run_i(run_d), .edge_o(y_edge)
    );

    assign in_ready   = in_ready_q;
    assign edge_rst_b = edge_rst_b_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_edge_pair_gen.sv
// tb_edge_pair_gen: randomized and directed frames checked every cycle against a frame-age model
module tb_edge_pair_gen;
    localparam int G = 2;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] x_val, y_val;
    logic       x_edge, y_edge, edge_rst_b, frame_done;

    int n_chk = 0;
    int n_fail = 0;

    int         age = -1;
    logic       rok = 1'b0;
    logic [3:0] mx = '0, my = '0;
    logic       idle, run;
    int         k;

    edge_pair_gen #(.VAL_W(4), .GAP_CYC(G)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
        .x_val(x_val), .y_val(y_val), .x_edge(x_edge), .y_edge(y_edge),
        .edge_rst_b(edge_rst_b), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (age %0d x=%0d y=%0d) at %0t", nm, act, exp, age, mx, my, $time);
        end
    endtask

    // Model: age = cycles since the accepting edge; 1..G is CLEAR, G+1..G+N is RUN, G+N+1 is frame_done
    initial forever begin
        @(posedge clk);
        if (rst_b) begin
            idle = !(age >= 1 && age <= G + N);
            if (idle && rok && in_valid) begin
                age = 1;
                mx  = x_val;
                my  = y_val;
            end else if (!idle) age++;
            else age = -1;
            rok = 1'b1;
        end else begin
            age = -1;
            rok = 1'b0;
        end
        @(negedge clk);
        if (!rst_b) begin
            age = -1;
            rok = 1'b0;
        end
        run = (age >= G + 1 && age <= G + N);
        k   = age - G - 1;
        chk("in_ready",   in_ready,   rok && !(age >= 1 && age <= G + N));
        chk("edge_rst_b", edge_rst_b, rok && !(age >= 1 && age <= G));
        chk("x_edge",     x_edge,     run && k >= int'(mx));
        chk("y_edge",     y_edge,     run && k >= int'(my));
        chk("frame_done", frame_done, age == G + N + 1);
        if (mx == 4 && my == 9) begin
            if (age == 1)  chk("lit49_clr1", edge_rst_b, 1'b0);
            if (age == 2)  chk("lit49_clr2", edge_rst_b, 1'b0);
            if (age == 6)  chk("lit49_x6",   x_edge,     1'b0);
            if (age == 7)  chk("lit49_x7",   x_edge,     1'b1);
            if (age == 11) chk("lit49_y11",  y_edge,     1'b0);
            if (age == 12) chk("lit49_y12",  y_edge,     1'b1);
            if (age == 18) chk("lit49_fd18", frame_done, 1'b0);
            if (age == 19) chk("lit49_fd19", frame_done, 1'b1);
            if (age == 19) chk("lit49_x19",  x_edge,     1'b0);
        end
        if (mx == 5 && my == 5) begin
            if (age == 7) chk("lit55_x7", x_edge, 1'b0);
            if (age == 7) chk("lit55_y7", y_edge, 1'b0);
            if (age == 8) chk("lit55_x8", x_edge, 1'b1);
            if (age == 8) chk("lit55_y8", y_edge, 1'b1);
        end
        if (mx == 0 && my == 15) begin
            if (age == 2)  chk("lit015_x2",  x_edge, 1'b0);
            if (age == 3)  chk("lit015_x3",  x_edge, 1'b1);
            if (age == 17) chk("lit015_y17", y_edge, 1'b0);
            if (age == 18) chk("lit015_y18", y_edge, 1'b1);
            if (age == 18) chk("lit015_x18", x_edge, 1'b1);
        end
        if (!rst_b) begin
            chk("rst_x",  x_edge,     1'b0);
            chk("rst_er", edge_rst_b, 1'b0);
            chk("rst_rd", in_ready,   1'b0);
        end
    end

    task automatic send(input logic [3:0] xv, input logic [3:0] yv);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        x_val    = xv;
        y_val    = yv;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            $display("FAIL send_timeout: in_ready 0 for 64 cycles, expected 1");
            $fatal(1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_val    = 4'($urandom);
        y_val    = 4'($urandom);
    endtask

    initial begin
        rst_b    = 1'b0;
        in_valid = 1'b0;
        x_val    = '0;
        y_val    = '0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        send(4'd4, 4'd9);
        repeat (20) @(posedge clk);
        send(4'd5, 4'd5);
        repeat (20) @(posedge clk);
        send(4'd0, 4'd15);
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            x_val = 4'($urandom);
            y_val = 4'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        send(4'd3, 4'd11);
        repeat (9) @(posedge clk);
        #3 rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        repeat (30) @(posedge clk);
        send(4'd4, 4'd9);
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 2) != 0);
            x_val    = 4'($urandom);
            y_val    = 4'($urandom);
        end
        in_valid = 1'b0;
        repeat (25) @(posedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
